// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch + IF/ID pipeline register.
//
// Issues word-addressed fetches over a req/ack handshake. The ack may arrive
// in the same cycle as req. The stage presents the fetched instruction and
// its PC to decode.
//   - stall     : freezes IF/ID; a word that lands while stalled is parked in
//                 a one-entry buffer (HOLD) and requests pause.
//   - br_taken  : flushes IF/ID to a bubble and redirects the PC. An
//                 un-acked wrong-path request must complete first (DRAIN),
//                 because the address has to stay stable until ack.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold IF/ID contents
//   br_taken, br_target      redirect request and address
//   imem_req, imem_addr      fetch request / word address (= fetch_pc)
//   imem_ack, imem_rdata     single-cycle response and instruction word
//   instr_id, pc_id, valid_id  IF/ID register (valid_id=0 -> bubble)
module fetch_stage #(
    parameter int                  PC_W      = 16,
    parameter int                  INSTR_W   = 16,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_id,
    output logic [PC_W-1:0]    pc_id,
    output logic               valid_id
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    redir_pc_q, redir_pc_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [PC_W-1:0]    buf_pc_q, buf_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    // No request is in flight while a word is parked in the buffer.
    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = fetch_pc_q;
    assign instr_id  = instr_q;
    assign pc_id     = pc_q;
    assign valid_id  = valid_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        redir_pc_d  = redir_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        valid_d     = valid_q;

        unique case (state_q)
            FETCH: begin
                if (br_taken && imem_ack) begin
                    // Wrong-path word arrived with the branch: drop it and
                    // redirect immediately.
                    fetch_pc_d = br_target;
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                end else if (br_taken) begin
                    redir_pc_d = br_target;
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    state_d    = DRAIN;
                end else if (imem_ack && !stall) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_ONE;
                end else if (imem_ack) begin
                    buf_instr_d = imem_rdata;
                    buf_pc_d    = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + PC_ONE;
                    state_d     = HOLD;
                end else if (!stall) begin
                    // Memory wait: decode sees bubbles.
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    fetch_pc_d = br_target;
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    state_d    = FETCH;
                end else if (!stall) begin
                    instr_d = buf_instr_q;
                    pc_d    = buf_pc_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (br_taken) redir_pc_d = br_target;
                if (imem_ack) begin
                    // A branch in the same cycle as the ack is the newest.
                    fetch_pc_d = br_taken ? br_target : redir_pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            redir_pc_q  <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            redir_pc_q  <= redir_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
        end
    end

endmodule
